// File: rtl/sort_ctrl_pkg.sv
// Shared definitions for the sort job controller: FSM state encoding and
// the pad-word selection for short jobs.
package sort_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FIRE  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Pad bit that makes unused slots sort to the tail: ones when ascending,
  // zeros when descending (unsigned compare).
  function automatic logic pad_bit(input string com_style);
    return (com_style == "DOWN") ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/sort_timeout_cnt.sv
// Watchdog counter for the sorter round trip. Held at zero while cleared,
// counts while enabled, and flags expiry on the last allowed cycle so the
// parent can register its error pulse at exactly TIMEOUT cycles.
module sort_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] L_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Count cycles since launch; saturate so a stuck enable cannot wrap.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != L_LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == L_LAST);

endmodule

// File: rtl/sort_job_ctrl.sv
// Sort job controller: gathers a serial burst into a parallel sorter word,
// launches the external sorter, waits (with timeout) for its result, then
// streams back only the loaded number of words. All outputs are registers.
module sort_job_ctrl
  import sort_ctrl_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    DATA_CNT   = 8,
  parameter string COM_STYLE  = "UP",
  parameter int    TIMEOUT    = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic                           m_last,
  output logic                           srt_wr_en,
  output logic [DATA_WIDTH*DATA_CNT-1:0] srt_wr_data,
  input  logic                           srt_cmp_en,
  input  logic [DATA_WIDTH*DATA_CNT-1:0] srt_cmp_data,
  output logic                           busy,
  output logic                           err_timeout,
  output logic [15:0]                    job_cnt
);

  localparam int IDX_W = (DATA_CNT > 1) ? $clog2(DATA_CNT) : 1;
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0]      L_LAST_SLOT = CNT_W'(DATA_CNT - 1);
  localparam logic [DATA_WIDTH-1:0] L_PAD       = {DATA_WIDTH{pad_bit(COM_STYLE)}};

  state_t                                r_state;
  logic                                  r_s_ready;
  logic                                  r_m_valid;
  logic                                  r_m_last;
  logic [DATA_WIDTH-1:0]                 r_m_data;
  logic                                  r_wr_en;
  logic                                  r_err;
  logic [15:0]                           r_job_cnt;
  logic [CNT_W-1:0]                      r_n;
  logic [IDX_W-1:0]                      r_j;
  logic [DATA_CNT-1:0][DATA_WIDTH-1:0]   r_buf;
  logic [DATA_CNT-1:0][DATA_WIDTH-1:0]   r_res;

  logic             w_s_fire;
  logic             w_m_fire;
  logic             w_last_beat;
  logic             w_cnt_clear;
  logic             w_expire;
  logic [IDX_W-1:0] w_j_next;
  logic             w_j_next_last;

  assign w_s_fire      = s_valid && r_s_ready;
  assign w_m_fire      = r_m_valid && m_ready;
  // r_n is zero in IDLE, so this also covers a one-slot sorter on beat one.
  assign w_last_beat   = s_last || (r_n == L_LAST_SLOT);
  assign w_cnt_clear   = (r_state != ST_FIRE) && (r_state != ST_WAIT);
  assign w_j_next      = r_j + 1'b1;
  assign w_j_next_last = ({1'b0, w_j_next} == (r_n - 1'b1));

  sort_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_cnt_clear),
    .i_en     (!w_cnt_clear),
    .o_expire (w_expire)
  );

  // Job sequencing: load, launch, wait/timeout, drain; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
      r_wr_en   <= 1'b0;
      r_err     <= 1'b0;
      r_job_cnt <= '0;
      r_n       <= '0;
      r_j       <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          r_s_ready <= 1'b1;
          if (w_s_fire) begin
            r_n <= r_n + 1'b1;
            if (w_last_beat) begin
              r_state   <= ST_FIRE;
              r_s_ready <= 1'b0;
              r_wr_en   <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_FIRE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (srt_cmp_en) begin
            r_state   <= ST_DRAIN;
            r_m_valid <= 1'b1;
            r_m_data  <= srt_cmp_data[DATA_WIDTH-1:0];
            r_m_last  <= (r_n == CNT_W'(1));
            r_j       <= '0;
          end else if (w_expire) begin
            r_state   <= ST_IDLE;
            r_err     <= 1'b1;
            r_n       <= '0;
            r_s_ready <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_m_fire) begin
            if (r_m_last) begin
              r_state   <= ST_IDLE;
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_job_cnt <= r_job_cnt + 16'd1;
              r_n       <= '0;
              r_s_ready <= 1'b1;
            end else begin
              r_j      <= w_j_next;
              r_m_data <= r_res[w_j_next];
              r_m_last <= w_j_next_last;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Load and result buffers. The first beat pre-fills every other slot with
  // the pad word so a short job needs no separate padding step.
  // NOTE: data buffers carry no reset; control state alone decides whether
  // their contents are ever used, so resetting them would only add fan-out.
  always_ff @(posedge clk) begin
    if (w_s_fire) begin
      if (r_state == ST_IDLE) begin
        r_buf    <= {DATA_CNT{L_PAD}};
        r_buf[0] <= s_data;
      end else begin
        r_buf[r_n[IDX_W-1:0]] <= s_data;
      end
    end
    if ((r_state == ST_WAIT) && srt_cmp_en) begin
      r_res <= srt_cmp_data;
    end
  end

  assign s_ready     = r_s_ready;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign m_last      = r_m_last;
  assign srt_wr_en   = r_wr_en;
  assign srt_wr_data = r_buf;
  assign busy        = (r_state != ST_IDLE);
  assign err_timeout = r_err;
  assign job_cnt     = r_job_cnt;

endmodule
